// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared constants, FSM encoding and buffer entry type for the fetch controller
package fetch_ctrl_pkg;

  // Reset is asserted when rst equals this level
  localparam logic RST_ENABLE = 1'b0;

  // Boot vector used as the default fetch address after reset
  localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc0_0000;

  // Bit of if_exception_type that flags a misaligned fetch address
  localparam int EXC_MISALIGNED_BIT = 30;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        misaligned;
  } fetch_entry_t;

  // Expand the single exception flag into the 32-bit decode-side exception word
  function automatic logic [31:0] exc_type(input logic misaligned);
    logic [31:0] t;
    t = '0;
    t[EXC_MISALIGNED_BIT] = misaligned;
    return t;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - single-entry output buffer between fetch and decode
module fetch_buf
  import fetch_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         load,
  input  fetch_entry_t load_entry,
  input  logic         consume,
  output logic         valid,
  output fetch_entry_t entry
);

  // Flush beats load, and a load in the same cycle as a consume keeps the entry valid
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      valid <= 1'b0;
      entry <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      entry <= load_entry;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch FSM and pc over an SRAM-like bus with one outstanding request
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exception,
  input  logic [31:0] exception_pc,
  input  logic        branch,
  input  logic [31:0] branch_pc,
  input  logic        stall,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic [31:0] if_exception_type
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc;
  logic [31:0]  req_addr;
  logic         discard;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic         buf_valid;
  logic         consume;
  logic         buf_free;
  logic         aligned;
  logic         buf_load;
  fetch_entry_t buf_entry;
  fetch_entry_t buf_out;

  assign redirect    = exception | branch;
  assign redirect_pc = exception ? exception_pc : branch_pc;
  assign consume     = buf_valid & ~stall;
  assign buf_free    = ~buf_valid | consume;
  assign aligned     = (pc[1:0] == 2'b00);
  assign inst_addr   = req_addr;

  // State register
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) state <= S_IDLE;
    else                   state <= state_nxt;
  end

  // Next state: a request starts only from an aligned pc with room in the buffer and no redirect
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!redirect && buf_free && aligned) state_nxt = S_ADDR;
      S_ADDR:  if (inst_addr_ok) state_nxt = S_DATA;
      S_DATA:  if (inst_data_ok) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs: bus request while in S_ADDR, buffer load for a kept response or a misaligned pc
  always_comb begin
    inst_req  = 1'b0;
    buf_load  = 1'b0;
    buf_entry = '0;
    case (state)
      S_IDLE: begin
        if (!redirect && buf_free && !aligned) begin
          buf_load  = 1'b1;
          buf_entry = '{pc: pc, inst: 32'h0, misaligned: 1'b1};
        end
      end
      S_ADDR: inst_req = 1'b1;
      S_DATA: begin
        if (inst_data_ok && !discard && !redirect) begin
          buf_load  = 1'b1;
          buf_entry = '{pc: req_addr, inst: inst_rdata, misaligned: 1'b0};
        end
      end
      default: ;
    endcase
  end

  // pc, latched request address and the discard flag for responses made stale by a redirect
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      pc       <= RESET_PC;
      req_addr <= 32'h0;
      discard  <= 1'b0;
    end else begin
      if (state == S_IDLE && state_nxt == S_ADDR) req_addr <= pc;
      if (redirect)                              pc <= redirect_pc;
      else if (state == S_DATA && buf_load)      pc <= req_addr + 32'd4;
      if (state == S_DATA && inst_data_ok)       discard <= 1'b0;
      else if (redirect && state != S_IDLE)      discard <= 1'b1;
    end
  end

  fetch_buf u_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect),
    .load       (buf_load),
    .load_entry (buf_entry),
    .consume    (consume),
    .valid      (buf_valid),
    .entry      (buf_out)
  );

  assign if_valid          = buf_valid;
  assign if_pc             = buf_out.pc;
  assign if_inst           = buf_out.inst;
  assign if_exception_type = exc_type(buf_out.misaligned);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard bench for fetch_ctrl with a programmable-latency bus model
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        exception, branch, stall;
  logic [31:0] exception_pc, branch_pc;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        if_valid;
  logic [31:0] if_pc, if_inst, if_exception_type;

  fetch_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .exception         (exception),
    .exception_pc      (exception_pc),
    .branch            (branch),
    .branch_pc         (branch_pc),
    .stall             (stall),
    .inst_req          (inst_req),
    .inst_addr         (inst_addr),
    .inst_addr_ok      (inst_addr_ok),
    .inst_data_ok      (inst_data_ok),
    .inst_rdata        (inst_rdata),
    .if_valid          (if_valid),
    .if_pc             (if_pc),
    .if_inst           (if_inst),
    .if_exception_type (if_exception_type)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] exc;
  } item_t;

  item_t       exp_q[$];
  logic [31:0] addr_q[$];
  item_t       e;
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_cons = 0;

  int          addr_delay = 0;
  int          wcnt = 0;
  bit          pend = 0;
  bit          stray = 0;
  bit          ovr_en = 0;
  logic [31:0] pend_addr = 32'h0;
  bit          req_prev = 0;
  logic [31:0] held_addr = 32'h0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hffff_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic push_item(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] exc);
    exp_q.push_back(item_t'{pc: pc, inst: inst, exc: exc});
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_req(input bit need_ok);
    int t;
    t = 0;
    while (!(inst_req && (!need_ok || inst_addr_ok)) && t < 200) begin
      cyc(1);
      t++;
    end
    if (t >= 200) timeout("wait_req");
  endtask

  task automatic take();
    int t;
    t = 0;
    while (!if_valid && t < 200) begin
      cyc(1);
      t++;
    end
    if (t >= 200) timeout("take");
    stall = 1'b0;
    cyc(1);
    stall = 1'b1;
  endtask

  task automatic redirect(input bit exc, input logic [31:0] epc, input bit br, input logic [31:0] bpc);
    exception = exc;
    exception_pc = epc;
    branch = br;
    branch_pc = bpc;
    cyc(1);
    exception = 1'b0;
    branch = 1'b0;
  endtask

  // Bus model: inputs change 1 time unit after the rising edge
  initial begin
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      inst_rdata = 32'h0;
      if (stray) begin
        inst_data_ok = 1'b1;
        inst_rdata = 32'h5555_aaaa;
        stray = 0;
      end else if (!rst) begin
        pend = 0;
        wcnt = 0;
      end else if (pend) begin
        inst_data_ok = 1'b1;
        inst_rdata = ovr_en ? 32'hdead_beef : mem(pend_addr);
        pend = 0;
      end else if (inst_req) begin
        if (wcnt >= addr_delay) begin
          inst_addr_ok = 1'b1;
          pend = 1;
          pend_addr = inst_addr;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every consume and every address handshake
  always @(negedge clk) begin
    if (!rst) begin
      req_prev <= 0;
    end else begin
      if (if_valid && !stall) begin
        n_cons++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: if_pc %h with nothing expected", if_pc);
        end else begin
          e = exp_q.pop_front();
          check("if_pc", if_pc, e.pc);
          check("if_inst", if_inst, e.inst);
          check("if_exception_type", if_exception_type, e.exc);
        end
      end
      if (ovr_en && if_valid) begin
        n_cmp++;
        if (if_inst === 32'hdead_beef) begin
          n_err++;
          $display("FAIL discarded_data: if_inst %h must never appear", if_inst);
        end
      end
      if (inst_req && inst_addr_ok) begin
        if (addr_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_req: inst_addr %h with nothing expected", inst_addr);
        end else begin
          check("inst_addr", inst_addr, addr_q.pop_front());
        end
      end
      if (inst_req && req_prev) check("inst_addr_stable", inst_addr, held_addr);
      held_addr <= inst_addr;
      req_prev <= inst_req && !inst_addr_ok;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1'b0;
    stall = 1'b1;
    exception = 1'b0;
    branch = 1'b0;
    exception_pc = 32'h0;
    branch_pc = 32'h0;
    cyc(4);
    check("rst_inst_req", {31'h0, inst_req}, 32'h0);
    check("rst_inst_addr", inst_addr, 32'h0);
    check("rst_if_valid", {31'h0, if_valid}, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_inst", if_inst, 32'h0);
    check("rst_if_exc", if_exception_type, 32'h0);

    // Stream from reset with a stray data_ok right at release
    addr_q.push_back(32'hbfc0_0000);
    addr_q.push_back(32'hbfc0_0004);
    addr_q.push_back(32'hbfc0_0008);
    addr_q.push_back(32'hbfc0_000c);
    push_item(32'hbfc0_0000, mem(32'hbfc0_0000), 32'h0);
    push_item(32'hbfc0_0004, mem(32'hbfc0_0004), 32'h0);
    push_item(32'hbfc0_0008, mem(32'hbfc0_0008), 32'h0);
    stray = 1;
    cyc(1);
    rst = 1'b1;
    stall = 1'b0;
    t = 0;
    while (n_cons < 3 && t < 200) begin
      cyc(1);
      t++;
    end
    if (t >= 200) timeout("stream");
    stall = 1'b1;
    cyc(8);

    // Held buffer under stall, no new request
    check("stall_if_valid", {31'h0, if_valid}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      check("stall_no_req", {31'h0, inst_req}, 32'h0);
      check("stall_if_pc", if_pc, 32'hbfc0_000c);
      check("stall_if_inst", if_inst, mem(32'hbfc0_000c));
      cyc(1);
    end
    addr_q.push_back(32'hbfc0_0010);
    push_item(32'hbfc0_000c, mem(32'hbfc0_000c), 32'h0);
    take();
    cyc(10);

    // Branch in S_DATA on the data_ok cycle drops dead_beef
    addr_q.push_back(32'hbfc0_0014);
    addr_q.push_back(32'h8000_0100);
    push_item(32'hbfc0_0010, mem(32'hbfc0_0010), 32'h0);
    ovr_en = 1;
    take();
    wait_req(1);
    cyc(1);
    redirect(1'b0, 32'h0, 1'b1, 32'h8000_0100);
    cyc(1);
    ovr_en = 0;
    cyc(10);
    addr_q.push_back(32'h8000_0104);
    push_item(32'h8000_0100, mem(32'h8000_0100), 32'h0);
    take();
    cyc(10);

    // Exception wins over a simultaneous branch
    addr_q.push_back(32'hbfc0_0380);
    redirect(1'b1, 32'hbfc0_0380, 1'b1, 32'h8000_0000);
    cyc(10);
    addr_q.push_back(32'hbfc0_0384);
    push_item(32'hbfc0_0380, mem(32'hbfc0_0380), 32'h0);
    take();
    cyc(10);

    // Misaligned target: no request, exception entry repeats until redirected
    redirect(1'b0, 32'h0, 1'b1, 32'h8000_0002);
    for (int i = 0; i < 6; i++) begin
      check("misaligned_no_req", {31'h0, inst_req}, 32'h0);
      cyc(1);
    end
    check("misaligned_if_exc", if_exception_type, 32'h4000_0000);
    push_item(32'h8000_0002, 32'h0, 32'h4000_0000);
    push_item(32'h8000_0002, 32'h0, 32'h4000_0000);
    take();
    take();
    cyc(2);

    // Slow address handshake with a redirect on its second cycle
    addr_delay = 3;
    addr_q.push_back(32'h8000_0200);
    addr_q.push_back(32'h8000_0300);
    redirect(1'b0, 32'h0, 1'b1, 32'h8000_0200);
    wait_req(0);
    cyc(1);
    redirect(1'b0, 32'h0, 1'b1, 32'h8000_0300);
    cyc(20);
    addr_q.push_back(32'h8000_0304);
    push_item(32'h8000_0300, mem(32'h8000_0300), 32'h0);
    take();
    cyc(15);

    // pc wraps from the top of the address space
    addr_delay = 0;
    addr_q.push_back(32'hffff_fffc);
    addr_q.push_back(32'h0000_0000);
    addr_q.push_back(32'h0000_0004);
    redirect(1'b0, 32'h0, 1'b1, 32'hffff_fffc);
    cyc(10);
    push_item(32'hffff_fffc, mem(32'hffff_fffc), 32'h0);
    push_item(32'h0000_0000, mem(32'h0000_0000), 32'h0);
    take();
    take();
    cyc(10);

    // Reset in the middle of a pending address phase
    addr_delay = 5;
    redirect(1'b0, 32'h0, 1'b1, 32'h8000_0400);
    wait_req(0);
    cyc(1);
    rst = 1'b0;
    addr_delay = 0;
    cyc(3);
    check("midrst_inst_req", {31'h0, inst_req}, 32'h0);
    check("midrst_if_valid", {31'h0, if_valid}, 32'h0);
    check("midrst_inst_addr", inst_addr, 32'h0);
    addr_q.push_back(32'hbfc0_0000);
    addr_q.push_back(32'hbfc0_0004);
    push_item(32'hbfc0_0000, mem(32'hbfc0_0000), 32'h0);
    rst = 1'b1;
    cyc(10);
    take();
    cyc(15);

    check("addr_q_drained", addr_q.size(), 32'h0);
    check("exp_q_drained", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-low (asserted when rst == `RST_ENABLE, 1'b0).
REQ-003 SHALL have ports: exception  in  1  one-cycle redirect pulse, highest priority; exception_pc  in  32  its target.
REQ-004 SHALL have ports: branch  in  1  one-cycle redirect pulse; branch_pc  in  32  its target.
REQ-005 SHALL have ports: stall  in  1  decode not ready; if_valid && !stall = consume.
REQ-006 SHALL have ports: inst_req  out  1; inst_addr  out  32; inst_addr_ok  in  1; inst_data_ok  in  1; inst_rdata  in  32 (SRAM-like fetch bus, one outstanding request).
REQ-007 SHALL have ports: if_valid  out  1; if_pc  out  32; if_inst  out  32; if_exception_type  out  32 (decode-side output).
REQ-008 SHALL have parameter: RESET_PC, default 32'hbfc0_0000, fetch address after reset.

Function
REQ-009 SHALL hold fetch pointer pc; FSM states S_IDLE, S_ADDR, S_DATA; one-entry output buffer (buf_valid, pc, inst, exc).
REQ-010 S_IDLE -> S_ADDR when pc[1:0]==0 and (!buf_valid or consume) and no redirect this cycle; req_addr <= pc on the transition.
REQ-011 S_ADDR: inst_req=1, inst_addr=req_addr, both stable until inst_addr_ok; addr_ok -> S_DATA next cycle.
REQ-012 S_DATA: inst_req=0; on inst_data_ok -> S_IDLE; if discard==0 load buffer {req_addr, inst_rdata, exc=0}, set buf_valid, pc <= req_addr+4.
REQ-013 Misaligned pc (pc[1:0]!=0) in S_IDLE with buffer free: no bus request; load buffer {pc, 32'h0, exc bit30=1}; pc unchanged until redirect.
REQ-014 if_exception_type = {1'b0, misaligned, 30'b0}; bits 31 and 29:0 SHALL be 0.
REQ-015 if_valid=buf_valid; if_pc/if_inst/if_exception_type from buffer; buffer cleared on consume unless reloaded same cycle.
REQ-016 Redirect (exception or branch; exception wins if both): pc <= target; buf_valid <= 0 same edge.
REQ-017 Redirect in S_ADDR: handshake still completes with unchanged req_addr; discard <= 1.
REQ-018 Redirect in S_DATA before or same cycle as data_ok: discard <= 1 (or response dropped directly); discarded response SHALL not update pc or buffer; discard cleared on that data_ok.
REQ-019 Redirect in S_IDLE: no request issued that cycle; next fetch from target.
REQ-020 pc+4 SHALL wrap modulo 2^32 (32'hffff_fffc -> 32'h0).
REQ-021 Zero-wait bus (addr_ok in first S_ADDR cycle, data_ok next cycle) SHALL give if_valid 3 cycles after leaving S_IDLE.

Reset
REQ-022 On reset: pc=RESET_PC, state=S_IDLE, buf_valid=0, discard=0, inst_req=0, inst_addr=0, if_valid=0, if_pc/if_inst/if_exception_type=0.
REQ-023 Reset mid-transaction SHALL abandon it; a data_ok arriving after reset while S_IDLE SHALL be ignored.

Structure
REQ-024 defines.vh SHALL hold `RST_ENABLE, reset PC, FSM state encodings, exception bit positions.
REQ-025 Output buffer SHALL be sub-module fetch_buf (load/consume/flush, single entry); FSM and pc stay in fetch_ctrl.

Verification
REQ-026 Reset release, zero-wait bus, stall=0 -> inst_addr 32'hbfc0_0000, bfc0_0004, bfc0_0008 in order; if_pc matches; if_inst = rdata.
REQ-027 stall=1 for 5 cycles with buf_valid -> if_pc/if_inst held, no new inst_req; stall=0 -> next fetch issued.
REQ-028 branch to 32'h8000_0100 during S_DATA, rdata 32'hdead_beef -> beef never on if_inst; next inst_addr 32'h8000_0100.
REQ-029 exception (32'hbfc0_0380) and branch (32'h8000_0000) same cycle -> next inst_addr 32'hbfc0_0380.
REQ-030 branch to 32'h8000_0002 -> no inst_req; if_valid=1, if_pc=32'h8000_0002, if_exception_type=32'h4000_0000.
REQ-031 addr_ok delayed 4 cycles, redirect on cycle 2 -> inst_addr stable all 4 cycles, response discarded, then target fetched.
